// File: rtl/core_bus_master_pkg.sv
// Shared micro-architecture types for the core-to-Avalon bus master:
// pointer/word types, the FSM state enum and the latched request payload.
package core_bus_master_pkg;

    localparam int unsigned PTR_W  = 30;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 10;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [WORD_W-1:0] word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } bus_master_state;

    // Request captured from the core when a transaction is accepted
    typedef struct packed {
        ptr              addr;
        logic            write;
        word             data;
        logic [BE_W-1:0] be;
    } bus_req_t;

    localparam word RD_ABORT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/core_bus_master.sv
// Single-outstanding bridge from the core bus port to a pipelined Avalon-MM
// master, with a per-transaction cycle timeout and a sticky error flag.
module core_bus_master
    import core_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  ptr                bus_addr,
    input  logic              bus_start,
    input  logic              bus_write,
    input  word               bus_data_wr,
    input  logic [BE_W-1:0]   bus_data_be,
    output logic              bus_ready,
    output word               bus_data_rd,
    output logic              bus_error,
    output logic [WORD_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [WORD_W-1:0] avl_writedata,
    output logic [BE_W-1:0]   avl_byteenable,
    input  logic              avl_waitrequest,
    input  logic [WORD_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid
);

    bus_master_state  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_req_t         req_q, req_d;
    logic             bus_ready_q, bus_ready_d;
    word              rd_data_q, rd_data_d;
    logic             error_q, error_d;
    logic             avl_read_q, avl_read_d;
    logic             avl_write_q, avl_write_d;
    logic             timeout_c;

    // cnt_q holds cycles already spent in flight, so this is the TIMEOUT-th cycle
    assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rd_data_d   = rd_data_q;
        error_d     = error_q;
        bus_ready_d = 1'b0;
        avl_read_d  = 1'b0;
        avl_write_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus_start) begin
                    req_d = '{addr:  bus_addr,
                              write: bus_write,
                              data:  bus_data_wr,
                              be:    bus_write ? bus_data_be : {BE_W{1'b1}}};
                    cnt_d       = '0;
                    state_d     = REQ;
                    avl_read_d  = ~bus_write;
                    avl_write_d = bus_write;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!avl_waitrequest) begin
                    if (req_q.write) begin
                        state_d     = DONE;
                        bus_ready_d = 1'b1;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (timeout_c) begin
                    if (!req_q.write) begin
                        rd_data_d = RD_ABORT_DATA;
                    end
                    error_d     = 1'b1;
                    state_d     = DONE;
                    bus_ready_d = 1'b1;
                end else begin
                    avl_read_d  = ~req_q.write;
                    avl_write_d = req_q.write;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (avl_readdatavalid) begin
                    rd_data_d   = avl_readdata;
                    state_d     = DONE;
                    bus_ready_d = 1'b1;
                end else if (timeout_c) begin
                    rd_data_d   = RD_ABORT_DATA;
                    error_d     = 1'b1;
                    state_d     = DONE;
                    bus_ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            bus_ready_q <= 1'b0;
            rd_data_q   <= '0;
            error_q     <= 1'b0;
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            bus_ready_q <= bus_ready_d;
            rd_data_q   <= rd_data_d;
            error_q     <= error_d;
            avl_read_q  <= avl_read_d;
            avl_write_q <= avl_write_d;
        end
    end

    assign bus_ready      = bus_ready_q;
    assign bus_data_rd    = rd_data_q;
    assign bus_error      = error_q;
    assign avl_address    = {req_q.addr, 2'b00};
    assign avl_read       = avl_read_q;
    assign avl_write      = avl_write_q;
    assign avl_writedata  = req_q.data;
    assign avl_byteenable = req_q.be;

endmodule

// File: tb/tb_core_bus_master.sv
// Bench for core_bus_master: directed scenarios with literal expectations,
// then randomized core/Avalon traffic checked every cycle against a transaction model.
module tb_core_bus_master;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst;
    logic [29:0] bus_addr;
    logic        bus_start;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_data_be;
    logic        bus_ready;
    logic [31:0] bus_data_rd;
    logic        bus_error;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;

    core_bus_master #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus_addr          (bus_addr),
        .bus_start         (bus_start),
        .bus_write         (bus_write),
        .bus_data_wr       (bus_data_wr),
        .bus_data_be       (bus_data_be),
        .bus_ready         (bus_ready),
        .bus_data_rd       (bus_data_rd),
        .bus_error         (bus_error),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_byteenable    (avl_byteenable),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one request in flight, its age in cycles,
    // whether the slave has taken it, and a one-cycle completion slot.
    bit          m_valid = 0;
    bit          m_busy, m_acc, m_done, m_wr;
    int unsigned m_age;
    logic        e_ready, e_err, e_read, e_write;
    logic [31:0] e_rd, e_addr, e_wdata;
    logic [3:0]  e_be;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_busy = 0; m_done = 0; m_acc = 0; m_wr = 0; m_age = 0;
            e_ready = 0; e_err = 0; e_read = 0; e_write = 0;
            e_rd = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        end else if (m_valid) begin
            e_ready = 0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (bus_start) begin
                    m_busy = 1; m_acc = 0; m_age = 0; m_wr = bus_write;
                    e_addr  = {bus_addr, 2'b00};
                    e_wdata = bus_data_wr;
                    e_be    = bus_write ? bus_data_be : 4'hF;
                    e_read  = !bus_write;
                    e_write = bus_write;
                end
            end else begin
                m_age++;
                if (!m_acc && !avl_waitrequest) begin
                    e_read = 0; e_write = 0;
                    if (m_wr) begin m_busy = 0; m_done = 1; e_ready = 1; end
                    else m_acc = 1;
                end else if (m_acc && avl_readdatavalid) begin
                    e_rd = avl_readdata;
                    m_busy = 0; m_done = 1; e_ready = 1;
                end else if (m_age >= TO) begin
                    if (!m_wr) e_rd = 32'hFFFF_FFFF;
                    e_err = 1; e_read = 0; e_write = 0;
                    m_busy = 0; m_done = 1; e_ready = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("bus_ready",      bus_ready,      e_ready);
            chk("bus_data_rd",    bus_data_rd,    e_rd);
            chk("bus_error",      bus_error,      e_err);
            chk("avl_read",       avl_read,       e_read);
            chk("avl_write",      avl_write,      e_write);
            chk("avl_address",    avl_address,    e_addr);
            chk("avl_writedata",  avl_writedata,  e_wdata);
            chk("avl_byteenable", avl_byteenable, e_be);
        end
    end

    task automatic start_req(input logic wr, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        bus_start = 1; bus_write = wr; bus_addr = a; bus_data_wr = d; bus_data_be = be;
    endtask

    int n_avl, n_rdy, rd_lat;
    logic acc_now;

    initial begin
        rst = 1; bus_start = 0; bus_write = 0; bus_addr = '0; bus_data_wr = '0;
        bus_data_be = '0; avl_waitrequest = 0; avl_readdata = '0; avl_readdatavalid = 0;
        step(); step();
        chk("reset_ready", bus_ready, 1'b0);
        chk("reset_error", bus_error, 1'b0);
        chk("reset_rdata", bus_data_rd, 32'h0);
        chk("reset_avl_rw", {avl_read, avl_write}, 2'b00);
        rst = 0;
        step();

        // Single zero-wait write
        start_req(1'b1, 30'h100, 32'hCAFE_BABE, 4'b0011);
        step(); bus_start = 0;
        chk("wr_address", avl_address, 32'h0000_0400);
        chk("wr_write_on", avl_write, 1'b1);
        chk("wr_data", avl_writedata, 32'hCAFE_BABE);
        chk("wr_be", avl_byteenable, 4'b0011);
        chk("wr_ready_early", bus_ready, 1'b0);
        step();
        chk("wr_write_off", avl_write, 1'b0);
        chk("wr_ready_at_2", bus_ready, 1'b1);
        step();
        chk("wr_ready_pulse", bus_ready, 1'b0);

        // Read with three waitrequest cycles and a two-cycle response latency
        start_req(1'b0, 30'h4, 32'h0, 4'h0);
        avl_waitrequest = 1;
        step(); bus_start = 0;
        chk("rd_address", avl_address, 32'h0000_0010);
        chk("rd_be", avl_byteenable, 4'hF);
        n_avl = 0; n_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            if (avl_read) n_avl++;
            if (bus_ready) n_rdy++;
            avl_waitrequest   = (i < 3);
            avl_readdatavalid = (i == 5);
            avl_readdata      = (i == 5) ? 32'h1234_5678 : 32'hDEAD_0000;
            step();
        end
        avl_readdatavalid = 0;
        chk("rd_read_cycles", n_avl, 4);
        chk("rd_ready_count", n_rdy, 1);
        chk("rd_data", bus_data_rd, 32'h1234_5678);

        // Back-to-back: write, then a read issued the cycle after bus_ready
        start_req(1'b1, 30'h3, 32'h1111_2222, 4'hF);
        step(); bus_start = 0;
        step();
        chk("b2b_ready1", bus_ready, 1'b1);
        step();
        start_req(1'b0, 30'h2A, 32'h0, 4'h0);
        step(); bus_start = 0;
        chk("b2b_rd_issue", avl_read, 1'b1);
        chk("b2b_rd_addr", avl_address, 32'h0000_00A8);
        step();
        avl_readdatavalid = 1; avl_readdata = 32'h0BAD_F00D;
        step();
        avl_readdatavalid = 0;
        chk("b2b_ready2", bus_ready, 1'b1);
        chk("b2b_rd_data", bus_data_rd, 32'h0BAD_F00D);
        step();

        // bus_start while a read is outstanding must be dropped
        start_req(1'b0, 30'h20, 32'h0, 4'h0);
        step(); bus_start = 0;
        n_avl = 0; n_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            if (avl_read || avl_write) n_avl++;
            if (bus_ready) n_rdy++;
            if (i == 1) start_req(1'b1, 30'h77, 32'h5555_AAAA, 4'h1);
            else bus_start = 0;
            avl_readdatavalid = (i == 2);
            avl_readdata      = 32'hA5A5_0F0F;
            step();
        end
        avl_readdatavalid = 0;
        chk("ign_avl_count", n_avl, 1);
        chk("ign_ready_count", n_rdy, 1);
        chk("ign_rd_data", bus_data_rd, 32'hA5A5_0F0F);

        // Unanswered read times out after TO cycles
        start_req(1'b0, 30'h55, 32'h0, 4'h0);
        avl_waitrequest = 1;
        step(); bus_start = 0;
        n_avl = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_ready) break;
            if (avl_read) n_avl++;
            step();
        end
        chk("to_read_cycles", n_avl, 8);
        chk("to_ready", bus_ready, 1'b1);
        chk("to_read_off", avl_read, 1'b0);
        chk("to_rd_data", bus_data_rd, 32'hFFFF_FFFF);
        chk("to_error", bus_error, 1'b1);
        avl_waitrequest = 0;
        step();
        start_req(1'b1, 30'h9, 32'h0000_0009, 4'h8);
        step(); bus_start = 0;
        step();
        chk("to_next_ready", bus_ready, 1'b1);
        chk("to_error_sticky", bus_error, 1'b1);
        step();

        // Reset in the middle of a read request
        start_req(1'b0, 30'h66, 32'h0, 4'h0);
        avl_waitrequest = 1;
        step(); bus_start = 0;
        chk("rst_pre_read", avl_read, 1'b1);
        rst = 1;
        step(); rst = 0;
        chk("rst_read_off", avl_read, 1'b0);
        chk("rst_ready", bus_ready, 1'b0);
        chk("rst_error", bus_error, 1'b0);
        step();
        chk("rst_idle_ready", bus_ready, 1'b0);
        chk("rst_idle_read", avl_read, 1'b0);
        avl_waitrequest = 0;
        step();

        // Random traffic with a reactive Avalon slave (-1 none, -2 never answers)
        rd_lat = -1;
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            bus_start   = ($urandom_range(0, 2) == 0);
            bus_write   = $urandom_range(0, 1);
            bus_addr    = 30'($urandom);
            bus_data_wr = $urandom;
            bus_data_be = 4'($urandom);
            avl_waitrequest = ($urandom_range(0, 9) < 6);
            avl_readdata    = $urandom;
            if (rd_lat == 0) begin
                avl_readdatavalid = 1; rd_lat = -1;
            end else if (rd_lat > 0) begin
                avl_readdatavalid = 0; rd_lat--;
            end else if (rd_lat == -1) begin
                avl_readdatavalid = ($urandom_range(0, 7) == 0);
            end else begin
                avl_readdatavalid = 0;
                if (bus_ready) rd_lat = -1;
            end
            acc_now = avl_read && !avl_waitrequest;
            step();
            if (rst) rd_lat = -1;
            else if (acc_now) rd_lat = ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, 3));
        end
        rst = 0; bus_start = 0; avl_readdatavalid = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/core_bus_master.md
CORE_BUS_MASTER -- requirements
Module: core_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles from bus request issue to completion before abort (1..1023).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bus_addr  input  ptr (30)  core word address.
REQ-005 SHALL have port bus_start  input  1  one-cycle request pulse from core.
REQ-006 SHALL have port bus_write  input  1  1 = write, 0 = read; valid with bus_start.
REQ-007 SHALL have port bus_data_wr  input  word (32)  write data; valid with bus_start.
REQ-008 SHALL have port bus_data_be  input  4  write byte enables; valid with bus_start.
REQ-009 SHALL have port bus_ready  output  1  one-cycle completion pulse to core.
REQ-010 SHALL have port bus_data_rd  output  word (32)  read data to core.
REQ-011 SHALL have port bus_error  output  1  sticky timeout flag.
REQ-012 SHALL have ports avl_address output 32, avl_read output 1, avl_write output 1, avl_writedata output 32, avl_byteenable output 4 (Avalon-MM master side).
REQ-013 SHALL have ports avl_waitrequest input 1, avl_readdata input 32, avl_readdatavalid input 1 (pipelined Avalon-MM read response).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT_RD, DONE.
REQ-015 SHALL, in IDLE on bus_start=1, latch addr, write, data_wr, be and enter REQ next cycle.
REQ-016 SHALL ignore bus_start in any state other than IDLE; no second request queued.
REQ-017 SHALL drive avl_address = {latched addr, 2'b00} and avl_writedata = latched data in REQ/WAIT_RD.
REQ-018 SHALL drive avl_byteenable = latched be for writes, 4'b1111 for reads.
REQ-019 SHALL assert avl_read (read) or avl_write (write) only in REQ, held stable until sampled with avl_waitrequest=0.
REQ-020 SHALL, in REQ with avl_waitrequest=0: write -> DONE; read -> WAIT_RD.
REQ-021 SHALL, in WAIT_RD on avl_readdatavalid=1, register avl_readdata into bus_data_rd and enter DONE.
REQ-022 SHALL ignore avl_readdatavalid outside WAIT_RD.
REQ-023 SHALL assert bus_ready for exactly the one cycle spent in DONE, then return to IDLE.
REQ-024 SHALL hold bus_data_rd stable from DONE until the next read completion.
REQ-025 SHALL give minimum latency bus_start->bus_ready of 2 cycles for writes, 3 for reads (zero wait, readdatavalid one cycle after accept).
REQ-026 SHALL count cycles spent in REQ+WAIT_RD with a counter cleared on entering REQ.
REQ-027 SHALL, when counter reaches TIMEOUT, deassert avl_read/avl_write, load bus_data_rd = 32'hFFFF_FFFF for reads, set bus_error, enter DONE.
REQ-028 SHALL keep bus_error set until rst; later transactions proceed normally.
REQ-029 SHALL give timeout precedence only if no response arrives in the same cycle; a response in the TIMEOUT cycle completes normally.

Reset
REQ-030 SHALL on rst: state IDLE, counter 0, bus_ready 0, bus_data_rd 0, bus_error 0, avl_read 0, avl_write 0, latched regs 0.
REQ-031 SHALL abort any in-flight transaction on rst without a bus_ready pulse; rst wins over all other inputs.

Structure
REQ-032 SHALL take ptr, word types from the shared uarch package; FSM state enum declared in that package as bus_master_state.
REQ-033 SHALL be a single module, no sub-modules; instantiated downstream of the core bus port.

Verification
REQ-034 Write addr 30'h100, data 32'hCAFEBABE, be 4'b0011, waitrequest 0 -> avl_address 32'h400, avl_write one cycle, bus_ready at start+2.
REQ-035 Read addr 30'h4, waitrequest held 3 cycles, readdatavalid 2 cycles later with 32'h12345678 -> avl_read held 4 cycles, bus_data_rd 32'h12345678, one bus_ready pulse.
REQ-036 TIMEOUT=8, read never answered -> avl_read drops after 8 cycles, bus_ready pulse, bus_data_rd 32'hFFFFFFFF, bus_error 1 and stays 1 through next good transaction.
REQ-037 bus_start pulsed while in WAIT_RD -> ignored; exactly one Avalon transaction and one bus_ready observed.
REQ-038 rst asserted in REQ with avl_read=1 -> next cycle avl_read 0, bus_ready 0, bus_error 0, state IDLE.
REQ-039 Back-to-back: bus_start in cycle after bus_ready -> accepted, second transaction completes with correct data.
